mbus_ice_tx_framer: RTL and testbench

Parametrised next-generation ICE-to-MBus transmit framer. Assembles bytes from the ICE bus interface into one MBus address (short 8-bit or long 32-bit, selected per frame) and a stream of DATA_W-bit words. Runs the MBus txreq/txack/txpend handshake per word. Adds a per-frame word limit with overflow drain, a watchdog timeout, and registered ack/nak result pulses to the ICE ack generator.

---
 rtl/mbus_ice_tx_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_mbus_ice_tx_framer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_ice_tx_framer.sv
// ICE-to-MBus transmit framer: packs ICE bytes into an address and data words,
// runs the per-word txreq/txack handshake and reports one ack/nak per frame.
module mbus_ice_tx_framer #(
  parameter int DATA_W         = 32,
  parameter int MAX_WORDS      = 64,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tx_frame_valid,
  input  logic                           tx_long_addr,
  input  logic                           tx_char_valid,
  input  logic [7:0]                     tx_char,
  input  logic                           tx_char_pending,
  output logic                           tx_char_advance,
  output logic [31:0]                    tx_mbus_txaddr,
  output logic [DATA_W-1:0]              tx_mbus_txdata,
  output logic                           tx_mbus_txreq,
  output logic                           tx_mbus_txpend,
  input  logic                           tx_mbus_txack,
  input  logic                           tx_mbus_txfail,
  input  logic                           tx_mbus_txsucc,
  output logic                           tx_mbus_txresp_ack,
  output logic                           tx_gen_ack,
  output logic                           tx_gen_nak,
  input  logic                           tx_acknak_valid,
  output logic                           tx_busy,
  output logic [$clog2(MAX_WORDS+1)-1:0] tx_word_count
);

  localparam int DATA_BYTES = DATA_W / 8;
  localparam int WC_W       = $clog2(MAX_WORDS + 1);
  localparam int TM_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(MAX_WORDS - 1);
  localparam logic [TM_W-1:0] TM_LAST   = TM_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0]      DATA_LAST = 2'(DATA_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_WAIT, S_TXREQ, S_TXACK, S_TXSUCC, S_DRAIN, S_RESULT
  } state_t;

  state_t            state_q, state_d;
  logic              long_q, long_d;
  logic [31:0]       txaddr_q, txaddr_d;
  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  logic              nak_q, nak_d;
  logic              txreq_q, txreq_d;
  logic              resp_q, resp_d;
  logic              gen_ack_q, gen_ack_d;
  logic              gen_nak_q, gen_nak_d;
  logic              busy_q, busy_d;

  logic timeout;
  logic txpend_w;

  assign timeout  = (TIMEOUT_CYCLES != 0) && (timer_q == TM_LAST);
  assign txpend_w = (state_q == S_TXREQ) && tx_char_pending && (wc_q != LAST_WORD);

  assign tx_char_advance    = tx_char_valid &&
                              ((state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DRAIN));
  assign tx_mbus_txaddr     = txaddr_q;
  assign tx_mbus_txdata     = txdata_q;
  assign tx_mbus_txreq      = txreq_q;
  assign tx_mbus_txpend     = txpend_w;
  assign tx_mbus_txresp_ack = resp_q;
  assign tx_gen_ack         = gen_ack_q;
  assign tx_gen_nak         = gen_nak_q;
  assign tx_busy            = busy_q;
  assign tx_word_count      = wc_q;

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    txaddr_d  = txaddr_q;
    txdata_d  = txdata_q;
    wc_d      = wc_q;
    bcnt_d    = bcnt_q;
    timer_d   = timer_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    nak_d     = nak_q;
    gen_ack_d = 1'b0;
    gen_nak_d = 1'b0;

    // One watchdog spans the whole request/accept/result exchange of a word.
    if ((state_q == S_TXREQ) || (state_q == S_TXACK) || (state_q == S_TXSUCC))
      timer_d = timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tx_frame_valid) begin
          long_d   = tx_long_addr;
          txaddr_d = '0;
          txdata_d = '0;
          wc_d     = '0;
          ovf_d    = 1'b0;
          bcnt_d   = '0;
          nak_d    = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (tx_char_valid) begin
          txaddr_d = (txaddr_q << 8) | {24'd0, tx_char};
          if (bcnt_q == (long_q ? 2'd3 : 2'd0)) begin
            bcnt_d  = '0;
            state_d = S_DATA;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_DATA: begin
        if (tx_char_valid) begin
          txdata_d = (txdata_q << 8) | DATA_W'(tx_char);
          if (bcnt_q == DATA_LAST) begin
            bcnt_d  = '0;
            state_d = S_WAIT;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      S_WAIT: begin
        timer_d = '0;
        state_d = S_TXREQ;
      end
      S_TXREQ: begin
        // Bytes still pending on the last permitted word means the frame is too long.
        if (tx_char_pending && (wc_q == LAST_WORD))
          ovf_d = 1'b1;
        if (timeout) begin
          nak_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (tx_mbus_txack) begin
          wc_d    = wc_q + 1'b1;
          pend_d  = txpend_w;
          state_d = S_TXACK;
        end
      end
      S_TXACK: begin
        if (timeout) begin
          nak_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (!tx_mbus_txack) begin
          state_d = pend_q ? S_DATA : S_TXSUCC;
        end
      end
      S_TXSUCC: begin
        if (timeout) begin
          nak_d   = 1'b1;
          state_d = S_DRAIN;
        end else if (tx_mbus_txfail) begin
          nak_d   = 1'b1;
          state_d = (ovf_q || tx_char_pending) ? S_DRAIN : S_RESULT;
        end else if (tx_mbus_txsucc) begin
          nak_d   = ovf_q;
          state_d = ovf_q ? S_DRAIN : S_RESULT;
        end
      end
      S_DRAIN: begin
        if (!tx_char_valid && !tx_char_pending)
          state_d = S_RESULT;
      end
      S_RESULT: begin
        if (!tx_acknak_valid)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_RESULT) && (state_q != S_RESULT)) begin
      gen_ack_d = !nak_d;
      gen_nak_d = nak_d;
    end

    txreq_d = (state_d == S_TXREQ);
    resp_d  = (state_d == S_RESULT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      long_q    <= 1'b0;
      txaddr_q  <= '0;
      txdata_q  <= '0;
      wc_q      <= '0;
      bcnt_q    <= '0;
      timer_q   <= '0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      nak_q     <= 1'b0;
      txreq_q   <= 1'b0;
      resp_q    <= 1'b0;
      gen_ack_q <= 1'b0;
      gen_nak_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      long_q    <= long_d;
      txaddr_q  <= txaddr_d;
      txdata_q  <= txdata_d;
      wc_q      <= wc_d;
      bcnt_q    <= bcnt_d;
      timer_q   <= timer_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      nak_q     <= nak_d;
      txreq_q   <= txreq_d;
      resp_q    <= resp_d;
      gen_ack_q <= gen_ack_d;
      gen_nak_q <= gen_nak_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mbus_ice_tx_framer.sv
// Bench for mbus_ice_tx_framer: a frame-level vector table driven through a byte
// feeder, a 4-phase MBus responder and an ack/nak busy model, plus a reset sequence.
module tb_mbus_ice_tx_framer;

  localparam int DATA_W         = 32;
  localparam int MAX_WORDS      = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_frame_valid = 1'b0;
  logic        tx_long_addr = 1'b0;
  logic        tx_char_valid;
  logic [7:0]  tx_char;
  logic        tx_char_pending;
  logic        tx_char_advance;
  logic [31:0] tx_mbus_txaddr;
  logic [31:0] tx_mbus_txdata;
  logic        tx_mbus_txreq;
  logic        tx_mbus_txpend;
  logic        tx_mbus_txack = 1'b0;
  logic        tx_mbus_txfail = 1'b0;
  logic        tx_mbus_txsucc = 1'b0;
  logic        tx_mbus_txresp_ack;
  logic        tx_gen_ack;
  logic        tx_gen_nak;
  logic        tx_acknak_valid = 1'b0;
  logic        tx_busy;
  logic [1:0]  tx_word_count;

  mbus_ice_tx_framer #(
    .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_frame_valid(tx_frame_valid), .tx_long_addr(tx_long_addr),
    .tx_char_valid(tx_char_valid), .tx_char(tx_char), .tx_char_pending(tx_char_pending),
    .tx_char_advance(tx_char_advance),
    .tx_mbus_txaddr(tx_mbus_txaddr), .tx_mbus_txdata(tx_mbus_txdata),
    .tx_mbus_txreq(tx_mbus_txreq), .tx_mbus_txpend(tx_mbus_txpend),
    .tx_mbus_txack(tx_mbus_txack), .tx_mbus_txfail(tx_mbus_txfail),
    .tx_mbus_txsucc(tx_mbus_txsucc), .tx_mbus_txresp_ack(tx_mbus_txresp_ack),
    .tx_gen_ack(tx_gen_ack), .tx_gen_nak(tx_gen_nak),
    .tx_acknak_valid(tx_acknak_valid), .tx_busy(tx_busy), .tx_word_count(tx_word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         long_a;
    logic [3:0]   nb;
    logic [103:0] bytes;   // first byte in the MSBs
    logic         ack_en;
    logic         succ;
    logic         fail;
    logic [1:0]   hold;    // extra cycles the ack/nak generator stays busy
    logic [31:0]  e_addr;
    logic [31:0]  e_d0;
    logic [31:0]  e_dl;
    logic [1:0]   e_wc;
    logic         e_ack;
    logic [2:0]   e_nreq;
    logic [3:0]   e_pend;
    logic [5:0]   e_reqhi;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          feed_idx = 0;
  int          feed_n = 0;
  logic [7:0]  feed_mem [0:15];
  logic        ack_en = 1'b0, succ_en = 1'b0, fail_en = 1'b0;
  int          hold_cfg = 0, rem = 0;
  logic        adv_s = 1'b0, req_s = 1'b0, pend_s = 1'b0, resp_s = 1'b0, pulse_s = 1'b0;
  logic        req_prev = 1'b0, last_pend = 1'b0;
  int          n_req, req_hi, n_ack, n_nak, n_resp, resp_early;
  logic [3:0]  pm;
  logic [31:0] cap_d [0:3];
  vec_t        vecs [0:5];
  vec_t        v6a, v6b;

  assign tx_char_valid   = (feed_idx < feed_n);
  assign tx_char         = feed_mem[feed_idx[3:0]];
  assign tx_char_pending = (feed_idx + 1 < feed_n);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Environment update just after the rising edge, monitor sample on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (adv_s && feed_idx < feed_n) feed_idx++;
    if (req_s) begin
      if (ack_en) tx_mbus_txack = 1'b1;
      last_pend = pend_s;
    end else if (tx_mbus_txack) begin
      tx_mbus_txack = 1'b0;
      if (!last_pend) begin
        tx_mbus_txsucc = succ_en;
        tx_mbus_txfail = fail_en;
      end
    end
    if (resp_s) begin
      tx_mbus_txsucc = 1'b0;
      tx_mbus_txfail = 1'b0;
    end
    if (pulse_s) begin
      pulse_s = 1'b0;
      rem = hold_cfg;
    end
    if (rem > 0) begin
      rem--;
      if (rem == 0) tx_acknak_valid = 1'b0;
    end
    @(negedge clk);
    adv_s  = tx_char_advance;
    req_s  = tx_mbus_txreq;
    pend_s = tx_mbus_txpend;
    resp_s = tx_mbus_txresp_ack;
    if (req_s && !req_prev) begin
      if (n_req < 4) begin
        cap_d[n_req] = tx_mbus_txdata;
        pm[n_req]    = pend_s;
      end
      n_req++;
    end
    if (req_s) req_hi++;
    req_prev = req_s;
    if (tx_gen_ack) n_ack++;
    if (tx_gen_nak) n_nak++;
    if (resp_s) begin
      if (n_resp == 0 && !(tx_gen_ack || tx_gen_nak)) resp_early++;
      n_resp++;
    end
    if (tx_gen_ack || tx_gen_nak) pulse_s = 1'b1;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 16; i++) feed_mem[i] = 8'h00;
    for (int i = 0; i < 13; i++) feed_mem[i] = v.bytes[103-8*i -: 8];
    feed_idx = 0;
    feed_n   = int'(v.nb);
    ack_en   = v.ack_en;
    succ_en  = v.succ;
    fail_en  = v.fail;
    hold_cfg = int'(v.hold);
    tx_acknak_valid = (v.hold != 2'd0);
    n_req = 0; req_hi = 0; n_ack = 0; n_nak = 0; n_resp = 0; resp_early = 0; pm = '0;
    for (int i = 0; i < 4; i++) cap_d[i] = '0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int cyc;
    int last;
    load(v);
    tx_long_addr   = v.long_a;
    tx_frame_valid = 1'b1;
    step();
    tx_frame_valid = 1'b0;
    tx_long_addr   = ~v.long_a;
    cyc = 0;
    while (tx_busy && cyc < 400) begin
      step();
      cyc++;
    end
    last = (n_req > 0) ? ((n_req > 4) ? 3 : n_req - 1) : 0;
    chk({tag, "_idle"},   {31'd0, tx_busy}, 32'd0);
    chk({tag, "_addr"},   tx_mbus_txaddr, v.e_addr);
    chk({tag, "_data0"},  cap_d[0], v.e_d0);
    chk({tag, "_datal"},  cap_d[last], v.e_dl);
    chk({tag, "_dataq"},  tx_mbus_txdata, v.e_dl);
    chk({tag, "_wc"},     {30'd0, tx_word_count}, {30'd0, v.e_wc});
    chk({tag, "_nreq"},   n_req, {29'd0, v.e_nreq});
    chk({tag, "_pend"},   {28'd0, pm}, {28'd0, v.e_pend});
    chk({tag, "_ackcnt"}, n_ack, {31'd0, v.e_ack});
    chk({tag, "_nakcnt"}, n_nak, {31'd0, ~v.e_ack});
    chk({tag, "_bytes"},  feed_idx, {28'd0, v.nb});
    chk({tag, "_resp"},   n_resp, 32'd1 + {30'd0, v.hold});
    chk({tag, "_respearly"}, resp_early, 32'd0);
    if (!v.ack_en) chk({tag, "_reqhi"}, req_hi, {26'd0, v.e_reqhi});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{long_a:1'b1, nb:4'd8,  bytes:104'hA0B1C2D3_11223344_00000000_00,
                ack_en:1'b1, succ:1'b1, fail:1'b0, hold:2'd0,
                e_addr:32'hA0B1C2D3, e_d0:32'h11223344, e_dl:32'h11223344,
                e_wc:2'd1, e_ack:1'b1, e_nreq:3'd1, e_pend:4'b0000, e_reqhi:6'd0};
    vecs[1] = '{long_a:1'b0, nb:4'd9,  bytes:104'h5F_01020304_05060708_00000000,
                ack_en:1'b1, succ:1'b1, fail:1'b0, hold:2'd3,
                e_addr:32'h0000005F, e_d0:32'h01020304, e_dl:32'h05060708,
                e_wc:2'd2, e_ack:1'b1, e_nreq:3'd2, e_pend:4'b0001, e_reqhi:6'd0};
    vecs[2] = '{long_a:1'b0, nb:4'd13, bytes:104'h33_10111213_20212223_30313233,
                ack_en:1'b1, succ:1'b1, fail:1'b0, hold:2'd1,
                e_addr:32'h00000033, e_d0:32'h10111213, e_dl:32'h20212223,
                e_wc:2'd2, e_ack:1'b0, e_nreq:3'd2, e_pend:4'b0001, e_reqhi:6'd0};
    vecs[3] = '{long_a:1'b0, nb:4'd9,  bytes:104'h44_AABBCCDD_01020304_00000000,
                ack_en:1'b0, succ:1'b0, fail:1'b0, hold:2'd0,
                e_addr:32'h00000044, e_d0:32'hAABBCCDD, e_dl:32'hAABBCCDD,
                e_wc:2'd0, e_ack:1'b0, e_nreq:3'd1, e_pend:4'b0001, e_reqhi:6'd16};
    vecs[4] = '{long_a:1'b0, nb:4'd5,  bytes:104'h7E_5AA50FF0_00000000_00000000,
                ack_en:1'b1, succ:1'b1, fail:1'b1, hold:2'd0,
                e_addr:32'h0000007E, e_d0:32'h5AA50FF0, e_dl:32'h5AA50FF0,
                e_wc:2'd1, e_ack:1'b0, e_nreq:3'd1, e_pend:4'b0000, e_reqhi:6'd0};
    vecs[5] = '{long_a:1'b1, nb:4'd8,  bytes:104'h01020304_CAFEF00D_00000000_00,
                ack_en:1'b1, succ:1'b0, fail:1'b1, hold:2'd0,
                e_addr:32'h01020304, e_d0:32'hCAFEF00D, e_dl:32'hCAFEF00D,
                e_wc:2'd1, e_ack:1'b0, e_nreq:3'd1, e_pend:4'b0000, e_reqhi:6'd0};
    v6a     = '{long_a:1'b1, nb:4'd8,  bytes:104'h12345678_ABCDEF01_00000000_00,
                ack_en:1'b1, succ:1'b1, fail:1'b0, hold:2'd0,
                e_addr:32'h12345678, e_d0:32'hABCDEF01, e_dl:32'hABCDEF01,
                e_wc:2'd1, e_ack:1'b1, e_nreq:3'd1, e_pend:4'b0000, e_reqhi:6'd0};
    v6b     = '{long_a:1'b0, nb:4'd5,  bytes:104'h9C_DEADBEEF_00000000_00000000,
                ack_en:1'b1, succ:1'b1, fail:1'b0, hold:2'd0,
                e_addr:32'h0000009C, e_d0:32'hDEADBEEF, e_dl:32'hDEADBEEF,
                e_wc:2'd1, e_ack:1'b1, e_nreq:3'd1, e_pend:4'b0000, e_reqhi:6'd0};

    load(vecs[0]);
    repeat (3) step();
    chk("reset_ctrl", {25'd0, tx_mbus_txreq, tx_mbus_txpend, tx_mbus_txresp_ack,
                       tx_gen_ack, tx_gen_nak, tx_busy, tx_char_advance}, 32'd0);
    chk("reset_addr", tx_mbus_txaddr, 32'd0);
    chk("reset_data", tx_mbus_txdata, 32'd0);
    chk("reset_wc",   {30'd0, tx_word_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
      repeat (2) step();
    end

    // Asynchronous reset in the middle of the data phase.
    begin
      int cyc;
      load(v6a);
      tx_long_addr   = 1'b1;
      tx_frame_valid = 1'b1;
      step();
      tx_frame_valid = 1'b0;
      cyc = 0;
      while (feed_idx < 6 && cyc < 100) begin
        step();
        cyc++;
      end
      chk("rst_reach_data", feed_idx, 32'd6);
      chk("rst_busy_before", {31'd0, tx_busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rst_async_ctrl", {25'd0, tx_mbus_txreq, tx_mbus_txpend, tx_mbus_txresp_ack,
                             tx_gen_ack, tx_gen_nak, tx_busy, tx_char_advance}, 32'd0);
      chk("rst_async_addr", tx_mbus_txaddr, 32'd0);
      chk("rst_async_data", tx_mbus_txdata, 32'd0);
      #1;
      reset_n = 1'b1;
      n_ack = 0;
      n_nak = 0;
      repeat (4) step();
      chk("rst_no_result", n_ack + n_nak, 32'd0);
      chk("rst_idle_after", {31'd0, tx_busy}, 32'd0);
      run_frame(v6b, "v6b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
